// File: rtl/door_plant_model.sv
`default_nettype none
// ============================================================================
//  Module   : door_plant_model
//  Purpose  : Roller door plant model. Integrates door position from the
//             motor commands (ml = close, mr = open), saturates at both end
//             stops, reports end-position sensors and latches a fault when
//             both motor windings are driven together.
//  Ports    : clk            system clock, rising edge
//             rst_n          asynchronous reset, active low
//             i_ml           motor left  (door closing)
//             i_mr           motor right (door opening)
//             o_sense_up     door fully open   (pos == POS_MAX)
//             o_sense_down   door fully closed (pos == 0)
//             o_pos          current door position
//             o_moving       position is advancing (driven, not stalled)
//             o_stall        motor driven against an end stop
//             o_fault        motor destroyed, sticky until reset
//             o_db_state     IDLE=0, OPENING=1, CLOSING=2, FAULT=3
//  Revision : 1.0  initial release
// ============================================================================
module door_plant_model #(
  parameter int PRESCALE = 200000,
  parameter int POS_MAX  = 100,
  parameter int POS_W    = 7,
  parameter int INIT_POS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ml,
  input  logic             i_mr,
  output logic             o_sense_up,
  output logic             o_sense_down,
  output logic [POS_W-1:0] o_pos,
  output logic             o_moving,
  output logic             o_stall,
  output logic             o_fault,
  output logic [1:0]       o_db_state
);

  // A prescaler of 1 still needs a 1-bit counter that simply stays at 0.
  localparam int c_PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(PRESCALE - 1);
  localparam logic [POS_W-1:0]     c_POS_MAX    = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0]     c_POS_INIT   = POS_W'(INIT_POS);
  localparam logic [POS_W-1:0]     c_POS_ONE    = POS_W'(1);
  localparam logic [c_PRESC_W-1:0] c_PRESC_ONE  = c_PRESC_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPENING = 2'd1,
    ST_CLOSING = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [POS_W-1:0]       r_pos;
  logic [POS_W-1:0]       w_pos_nxt;
  logic [c_PRESC_W-1:0]   r_presc;
  logic [c_PRESC_W-1:0]   w_presc_nxt;
  logic                   w_at_top;
  logic                   w_at_bot;

  assign w_at_top = (r_pos == c_POS_MAX);
  assign w_at_bot = (r_pos == '0);

  // --------------------------------------------------------------------------
  // State, position and prescaler registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pos   <= c_POS_INIT;
      r_presc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_presc <= w_presc_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and position integration
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_presc_nxt = '0;

    if (r_state == ST_FAULT) begin
      w_state_nxt = ST_FAULT;
    end else if (i_ml && i_mr) begin
      w_state_nxt = ST_FAULT;
    end else if (i_mr) begin
      w_state_nxt = ST_OPENING;
    end else if (i_ml) begin
      w_state_nxt = ST_CLOSING;
    end else begin
      w_state_nxt = ST_IDLE;
    end

    // Progress only accumulates while the drive direction is unchanged; any
    // state change (including a direct reversal) discards partial progress
    // because the prescaler default above is zero.
    if (w_state_nxt == r_state) begin
      if (r_state == ST_OPENING && !w_at_top) begin
        if (r_presc == c_PRESC_LAST) begin
          w_pos_nxt = r_pos + c_POS_ONE;
        end else begin
          w_presc_nxt = r_presc + c_PRESC_ONE;
        end
      end else if (r_state == ST_CLOSING && !w_at_bot) begin
        if (r_presc == c_PRESC_LAST) begin
          w_pos_nxt = r_pos - c_POS_ONE;
        end else begin
          w_presc_nxt = r_presc + c_PRESC_ONE;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registers only
  // --------------------------------------------------------------------------
  assign o_pos        = r_pos;
  assign o_sense_up   = w_at_top;
  assign o_sense_down = w_at_bot;
  assign o_stall      = ((r_state == ST_OPENING) && w_at_top) ||
                        ((r_state == ST_CLOSING) && w_at_bot);
  assign o_moving     = ((r_state == ST_OPENING) || (r_state == ST_CLOSING)) && !o_stall;
  assign o_fault      = (r_state == ST_FAULT);
  assign o_db_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_door_plant_model.sv
`default_nettype none
// ============================================================================
//  Module   : tb_door_plant_model
//  Purpose  : Self-checking bench for door_plant_model with a reference model
//             of the door expressed as direction, position and drive time.
//  Revision : 1.0  initial release
// ============================================================================
module tb_door_plant_model;

  localparam int PRESCALE = 4;
  localparam int POS_MAX  = 10;
  localparam int POS_W    = 7;
  localparam int INIT_POS = 0;

  logic             clk;
  logic             rst_n;
  logic             ml;
  logic             mr;
  logic             sense_up;
  logic             sense_down;
  logic [POS_W-1:0] pos;
  logic             moving;
  logic             stall;
  logic             fault;
  logic [1:0]       db_state;

  int n_checks = 0;
  int n_fail   = 0;

  door_plant_model #(
    .PRESCALE (PRESCALE),
    .POS_MAX  (POS_MAX),
    .POS_W    (POS_W),
    .INIT_POS (INIT_POS)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ml         (ml),
    .i_mr         (mr),
    .o_sense_up   (sense_up),
    .o_sense_down (sense_down),
    .o_pos        (pos),
    .o_moving     (moving),
    .o_stall      (stall),
    .o_fault      (fault),
    .o_db_state   (db_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: direction (0 idle, 1 open, 2 close, 3 fault), position
  // and number of edges of uninterrupted drive in the current direction.
  // A step happens every PRESCALE-th edge of uninterrupted, unblocked drive.
  // --------------------------------------------------------------------------
  int m_dir;
  int m_pos;
  int m_run;
  int m_nd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dir = 0;
      m_pos = INIT_POS;
      m_run = 0;
    end else begin
      if (m_dir == 3)          m_nd = 3;
      else if (ml && mr)       m_nd = 3;
      else if (mr)             m_nd = 1;
      else if (ml)             m_nd = 2;
      else                     m_nd = 0;
      if (m_nd != m_dir) begin
        m_dir = m_nd;
        m_run = 0;
      end else if (m_dir == 1 && m_pos < POS_MAX) begin
        m_run++;
        if (m_run % PRESCALE == 0) m_pos++;
      end else if (m_dir == 2 && m_pos > 0) begin
        m_run++;
        if (m_run % PRESCALE == 0) m_pos--;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int e_stall;
    e_stall = ((m_dir == 1 && m_pos == POS_MAX) || (m_dir == 2 && m_pos == 0)) ? 1 : 0;
    chk("pos",        int'(pos),        m_pos);
    chk("sense_up",   int'(sense_up),   (m_pos == POS_MAX) ? 1 : 0);
    chk("sense_down", int'(sense_down), (m_pos == 0) ? 1 : 0);
    chk("db_state",   int'(db_state),   m_dir);
    chk("fault",      int'(fault),      (m_dir == 3) ? 1 : 0);
    chk("stall",      int'(stall),      e_stall);
    chk("moving",     int'(moving),     ((m_dir == 1 || m_dir == 2) && e_stall == 0) ? 1 : 0);
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ml    = 1'b0;
    mr    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations
  // --------------------------------------------------------------------------
  initial begin
    ml    = 1'b0;
    mr    = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    // 1: reset state before any clock edge
    chk("rst_pos",        int'(pos),        0);
    chk("rst_sense_down", int'(sense_down), 1);
    chk("rst_sense_up",   int'(sense_up),   0);
    chk("rst_fault",      int'(fault),      0);
    chk("rst_db_state",   int'(db_state),   0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: full open stroke
    @(negedge clk);
    mr = 1'b1;                     // edge 0 is the next posedge
    ticks(1);
    chk("open_state_e0", int'(db_state), 1);
    chk("open_pos_e0",   int'(pos),      0);
    ticks(3);
    chk("open_pos_e3",   int'(pos),      0);
    ticks(1);
    chk("open_pos_e4",   int'(pos),      1);
    ticks(35);
    chk("open_pos_e39",  int'(pos),      9);
    ticks(1);
    chk("open_pos_e40",  int'(pos),      10);
    chk("open_up_e40",   int'(sense_up), 1);
    ticks(5);
    chk("open_stall",    int'(stall),    1);
    chk("open_moving",   int'(moving),   0);
    chk("open_pos_hold", int'(pos),      10);

    // 3: reversal mid-step at pos 5 with two edges of progress
    do_reset();
    @(negedge clk);
    mr = 1'b1;
    ticks(23);                     // after edge 22: pos 5, two edges into step
    chk("rev_pos_pre", int'(pos), 5);
    mr = 1'b0;
    ml = 1'b1;
    ticks(1);
    chk("rev_state",   int'(db_state), 2);
    chk("rev_pos_hold",int'(pos),      5);
    ticks(3);
    chk("rev_pos_e3",  int'(pos),      5);
    ticks(1);
    chk("rev_pos_e4",  int'(pos),      4);

    // 4: fault at pos 3
    ticks(4);
    chk("flt_pos_pre", int'(pos), 3);
    mr = 1'b1;                     // ml still 1
    ticks(1);
    ml = 1'b0;
    mr = 1'b0;
    chk("flt_fault",   int'(fault),    1);
    chk("flt_state",   int'(db_state), 3);
    ticks(100);
    chk("flt_fault_100", int'(fault), 1);
    chk("flt_pos_100",   int'(pos),   3);
    do_reset();
    ticks(1);
    chk("flt_cleared", int'(fault), 0);

    // 5: asynchronous reset mid-stroke at pos 6
    mr = 1'b1;
    ticks(25);                     // after edge 24: pos 6
    chk("ars_pos_pre", int'(pos), 6);
    #2 rst_n = 1'b0;               // mid low phase, next posedge is 3 units away
    #1;
    chk("ars_pos",        int'(pos),        0);
    chk("ars_sense_down", int'(sense_down), 1);
    chk("ars_state",      int'(db_state),   0);
    mr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 6: closing against the closed end stop
    ml = 1'b1;
    ticks(1);
    chk("stc_state",  int'(db_state), 2);
    chk("stc_stall",  int'(stall),    1);
    chk("stc_moving", int'(moving),   0);
    ticks(50);
    chk("stc_pos_50",   int'(pos),   0);
    chk("stc_stall_50", int'(stall), 1);
    ml = 1'b0;
    ticks(2);
    chk("stc_idle", int'(db_state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
